// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes rx, recovers LSB-first bytes, strobes data_valid / frame_err.
// Define UART_RX_PARITY_EN to receive 8E1/8O1 frames and add the parity_err strobe.
module uart_rx #(
    parameter int DIVISOR    = 286,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam logic [8:0] DIV  = 9'(DIVISOR);
    localparam logic [8:0] HALF = 9'(DIVISOR / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state, state_next;
    logic [8:0]  cnt, cnt_next;
    logic [2:0]  idx, idx_next;
    logic [7:0]  shift, shift_next;
    logic [7:0]  data_next;
    logic        dv_next, fe_next;
    logic        rx_p0, rx_p1, rx_p2;

`ifdef UART_RX_PARITY_EN
    logic        par_bit, par_next, pe_next;

    function automatic logic parity_bad(input logic [7:0] b, input logic p);
        return ((^b) ^ p) != PARITY_ODD;
    endfunction
`endif

    assign busy = (state != IDLE);

    // Stage p0/p1: metastability synchronizer; p2: edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            data       <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            data       <= data_next;
            data_valid <= dv_next;
            frame_err  <= fe_next;
`ifdef UART_RX_PARITY_EN
            parity_err <= pe_next;
`endif
        end
    end

    // Assembly registers carry no control meaning, so they are left unreset.
    always_ff @(posedge clk) begin
        shift <= shift_next;
`ifdef UART_RX_PARITY_EN
        par_bit <= par_next;
`endif
    end

    always_comb begin
        state_next = state;
        cnt_next   = (state == IDLE) ? 9'd0 : cnt + 9'd1;
        idx_next   = idx;
        shift_next = shift;
        data_next  = data;
        dv_next    = 1'b0;
        fe_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_bit;
        pe_next    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Only a genuine high-to-low transition starts a frame, so a stuck-low line is ignored.
                if (rx_p2 && !rx_p1) begin
                    state_next = START;
                    cnt_next   = 9'd0;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_next = 9'd0;
                    if (!rx_p1) begin
                        state_next = DATA;
                        idx_next   = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == DIV) begin
                    cnt_next        = 9'd0;
                    shift_next[idx] = rx_p1;
                    idx_next        = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == DIV) begin
                    cnt_next   = 9'd0;
                    par_next   = rx_p1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving mid stop bit leaves half a bit to catch a back-to-back start edge.
                if (cnt == DIV) begin
                    cnt_next   = 9'd0;
                    data_next  = shift;
                    dv_next    = rx_p1;
                    fe_next    = !rx_p1;
`ifdef UART_RX_PARITY_EN
                    pe_next    = parity_bad(shift, par_bit);
`endif
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit; parity scenario runs when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int DIVISOR  = 15;
    localparam int BIT_CLKS = DIVISOR + 1;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LATENCY = DIVISOR / 2 + (FRAME_BITS - 1) * BIT_CLKS + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic       pe_obs;

`ifdef UART_RX_PARITY_EN
    logic parity_err;
    assign pe_obs = parity_err;
`else
    assign pe_obs = 1'b0;
`endif

    uart_rx #(.DIVISOR(DIVISOR), .PARITY_ODD(1'b0)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .data_valid(data_valid),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int frame_start = 0;

    logic [7:0] exp_data[$];
    logic [2:0] exp_kind[$];
    logic [7:0] ev_data[$];
    logic [2:0] ev_kind[$];
    int         ev_cyc[$];

    // Kind encoding: {parity_err, frame_err, data_valid}.
    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err || pe_obs)) begin
            ev_data.push_back(data);
            ev_kind.push_back({pe_obs, frame_err, data_valid});
            ev_cyc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame and records what the receiver should report for it.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
        frame_start = cyc;
        exp_data.push_back(b);
        exp_kind.push_back({bad_par, ~stop, stop});
        rx = 1'b0;
        hold(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ bad_par;
        hold(BIT_CLKS);
`endif
        rx = stop;
        hold(BIT_CLKS);
    endtask

    task automatic test_reset;
        tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", data); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic;
        logic [7:0] d, ed;
        logic [2:0] k, ek;
        int t0, lat;
        send_frame(8'h55, 1'b1, 1'b0);
        t0 = frame_start;
        idle(4);
        tests++;
        if (ev_data.size() != 1) begin
            fails++; $display("FAIL basic_count got=%0d exp=1", ev_data.size());
            ev_data.delete(); ev_kind.delete(); ev_cyc.delete(); exp_data.delete(); exp_kind.delete();
        end else begin
            d = ev_data.pop_front(); k = ev_kind.pop_front(); lat = ev_cyc.pop_front() - t0;
            ed = exp_data.pop_front(); ek = exp_kind.pop_front();
            tests++; if (d !== ed) begin fails++; $display("FAIL basic_data got=%h exp=%h", d, ed); end
            tests++; if (k !== ek) begin fails++; $display("FAIL basic_kind got=%b exp=%b", k, ek); end
            tests++;
            if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
                fails++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LATENCY);
            end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy got=%b exp=0", busy); end
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        hold(4);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
        idle(10);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
        tests++; if (ev_data.size() != 0) begin fails++; $display("FAIL glitch_strobes got=%0d exp=0", ev_data.size()); end
        tests++; if (data !== 8'h55) begin fails++; $display("FAIL glitch_data got=%h exp=55", data); end
        ev_data.delete(); ev_kind.delete(); ev_cyc.delete();
        idle(8);
    endtask

    task automatic test_frame_err;
        logic [7:0] d, ed;
        logic [2:0] k, ek;
        send_frame(8'hA3, 1'b0, 1'b0);
        rx = 1'b0;
        hold(60);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_low_hold_busy got=%b exp=0", busy); end
        idle(BIT_CLKS);
        send_frame(8'h01, 1'b1, 1'b0);
        idle(4);
        tests++;
        if (ev_data.size() != 2) begin
            fails++; $display("FAIL ferr_count got=%0d exp=2", ev_data.size());
            ev_data.delete(); ev_kind.delete(); ev_cyc.delete(); exp_data.delete(); exp_kind.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                d = ev_data.pop_front(); k = ev_kind.pop_front(); void'(ev_cyc.pop_front());
                ed = exp_data.pop_front(); ek = exp_kind.pop_front();
                tests++; if (d !== ed) begin fails++; $display("FAIL ferr_data%0d got=%h exp=%h", i, d, ed); end
                tests++; if (k !== ek) begin fails++; $display("FAIL ferr_kind%0d got=%b exp=%b", i, k, ek); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d, ed;
        logic [2:0] k, ek;
        int c0, c1;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(4);
        tests++;
        if (ev_data.size() != 2) begin
            fails++; $display("FAIL b2b_count got=%0d exp=2", ev_data.size());
            ev_data.delete(); ev_kind.delete(); ev_cyc.delete(); exp_data.delete(); exp_kind.delete();
        end else begin
            c0 = ev_cyc[0]; c1 = ev_cyc[1];
            for (int i = 0; i < 2; i++) begin
                d = ev_data.pop_front(); k = ev_kind.pop_front(); void'(ev_cyc.pop_front());
                ed = exp_data.pop_front(); ek = exp_kind.pop_front();
                tests++; if (d !== ed) begin fails++; $display("FAIL b2b_data%0d got=%h exp=%h", i, d, ed); end
                tests++; if (k !== ek) begin fails++; $display("FAIL b2b_kind%0d got=%b exp=%b", i, k, ek); end
            end
            tests++;
            if (c1 - c0 != FRAME_BITS * BIT_CLKS) begin
                fails++; $display("FAIL b2b_spacing got=%0d exp=%0d", c1 - c0, FRAME_BITS * BIT_CLKS);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        logic [7:0] d, ed;
        logic [2:0] k, ek;
        b = 8'h3C;
        rx = 1'b0;
        hold(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            hold(BIT_CLKS);
        end
        rx = b[3];
        hold(8);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (data !== 8'h00) begin fails++; $display("FAIL rstmid_data got=%h exp=00", data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tests++; if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
            fails++; $display("FAIL rstmid_strobes got=%b%b exp=00", data_valid, frame_err);
        end
        hold(3);
        rst = 1'b0;
        idle(2 * BIT_CLKS);
        tests++; if (ev_data.size() != 0) begin fails++; $display("FAIL rstmid_aborted got=%0d exp=0", ev_data.size()); end
        ev_data.delete(); ev_kind.delete(); ev_cyc.delete();
        send_frame(8'h96, 1'b1, 1'b0);
        idle(4);
        tests++;
        if (ev_data.size() != 1) begin
            fails++; $display("FAIL rstmid_count got=%0d exp=1", ev_data.size());
            ev_data.delete(); ev_kind.delete(); ev_cyc.delete(); exp_data.delete(); exp_kind.delete();
        end else begin
            d = ev_data.pop_front(); k = ev_kind.pop_front(); void'(ev_cyc.pop_front());
            ed = exp_data.pop_front(); ek = exp_kind.pop_front();
            tests++; if (d !== ed) begin fails++; $display("FAIL rstmid_data96 got=%h exp=%h", d, ed); end
            tests++; if (k !== ek) begin fails++; $display("FAIL rstmid_kind got=%b exp=%b", k, ek); end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        logic [7:0] d, ed;
        logic [2:0] k, ek;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(BIT_CLKS);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        tests++;
        if (ev_data.size() != 2) begin
            fails++; $display("FAIL parity_count got=%0d exp=2", ev_data.size());
            ev_data.delete(); ev_kind.delete(); ev_cyc.delete(); exp_data.delete(); exp_kind.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                d = ev_data.pop_front(); k = ev_kind.pop_front(); void'(ev_cyc.pop_front());
                ed = exp_data.pop_front(); ek = exp_kind.pop_front();
                tests++; if (d !== ed) begin fails++; $display("FAIL parity_data%0d got=%h exp=%h", i, d, ed); end
                tests++; if (k !== ek) begin fails++; $display("FAIL parity_kind%0d got=%b exp=%b", i, k, ek); end
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(BIT_CLKS);
        test_basic();
        test_glitch();
        test_frame_err();
        idle(BIT_CLKS);
        test_back_to_back();
        idle(BIT_CLKS);
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        idle(BIT_CLKS);
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
